// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan decoder: legal glyph table,
// segment bit positions and digit-select classification.
package seg7_pkg;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    // Active-high glyphs for hex 0..F, bit SEG_A is the LSB.
    localparam logic [6:0] SEG7_PATTERNS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_ONE,
        SEL_MULTI
    } sel_kind_e;

    // Classifies an active-high select vector as zero-hot, one-hot or multi-hot.
    function automatic sel_kind_e sel_classify(input logic [7:0] act);
        int unsigned n;
        n = 0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (act[k]) n++;
        end
        if (n == 0)      return SEL_NONE;
        else if (n == 1) return SEL_ONE;
        else             return SEL_MULTI;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex glyph table: active-high pattern in,
// nibble plus legal flag out (nibble is 0 when the pattern is illegal).
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_pat,
    output logic [3:0] o_nibble,
    output logic       o_legal
);

    always_comb begin
        o_nibble = '0;
        o_legal  = 1'b0;
        for (int unsigned k = 0; k < 16; k++) begin
            if (i_pat == SEG7_PATTERNS[k]) begin
                o_nibble = 4'(k);
                o_legal  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Readback monitor for a multiplexed active-low 7-segment bus: recovers each
// digit's nibble once the bus is stable. Optional dp capture: SEG7_SCAN_DP_EN.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                seg_n,
    input  logic [NUM_DIGITS-1:0]     an_n,
`ifdef SEG7_SCAN_DP_EN
    input  logic                      dp_n,
    output logic [NUM_DIGITS-1:0]     dp,
`endif
    input  logic                      err_clr,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic [NUM_DIGITS-1:0]     dig_valid,
    output logic                      frame_done,
    output logic                      pat_err,
    output logic                      sel_err
);

`ifdef SEG7_SCAN_DP_EN
    localparam int unsigned BW = NUM_DIGITS + 8;
`else
    localparam int unsigned BW = NUM_DIGITS + 7;
`endif
    localparam int unsigned CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);

    logic [BW-1:0]           w_bus_in;
    logic [BW-1:0]           r_sync1;
    logic [BW-1:0]           r_s_bus;
    logic [BW-1:0]           r_p_bus;
    logic [CW-1:0]           r_cnt;
    logic [CW-1:0]           w_cnt_nxt;
    logic                    w_same;
    logic                    w_cap;
    logic [6:0]              w_s_seg;
    logic [NUM_DIGITS-1:0]   w_s_an;
    logic [7:0]              w_act;
    sel_kind_e               w_kind;
    logic [NUM_DIGITS-1:0]   w_capbit;
    logic [3:0]              w_nibble;
    logic                    w_legal;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_valid;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic                    r_frame;
    logic                    r_pat_err;
    logic                    r_sel_err;
`ifdef SEG7_SCAN_DP_EN
    logic                    w_s_dp;
    logic [NUM_DIGITS-1:0]   r_dp;

    assign w_bus_in = {dp_n, an_n, seg_n};
    assign w_s_dp   = r_s_bus[BW-1];
    assign dp       = r_dp;
`else
    assign w_bus_in = {an_n, seg_n};
`endif

    assign w_s_seg = r_s_bus[SEG_G:SEG_A];
    assign w_s_an  = r_s_bus[NUM_DIGITS+6:7];
    assign w_same  = (r_s_bus == r_p_bus);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!w_same)
            w_cnt_nxt = '0;
        else if (r_cnt != CW'(STABLE_CYCLES))
            w_cnt_nxt = r_cnt + 1'b1;
    end

    // Fires only on entry to STABLE_CYCLES-1; the !w_same term covers STABLE_CYCLES==1.
    assign w_cap = (w_cnt_nxt == CW'(STABLE_CYCLES - 1)) &&
                   (!w_same || (r_cnt != CW'(STABLE_CYCLES - 1)));

    always_comb begin
        w_act = '0;
        w_act[NUM_DIGITS-1:0] = ~w_s_an;
    end

    assign w_kind   = sel_classify(w_act);
    assign w_capbit = (w_cap && (w_kind == SEL_ONE)) ? ~w_s_an : '0;

    seg7_pattern_decode u_decode (
        .i_pat    (~w_s_seg),
        .o_nibble (w_nibble),
        .o_legal  (w_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= '1;
            r_s_bus   <= '1;
            r_p_bus   <= '1;
            r_cnt     <= '0;
            r_digits  <= '0;
            r_valid   <= '0;
            r_seen    <= '0;
            r_frame   <= 1'b0;
            r_pat_err <= 1'b0;
            r_sel_err <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
            r_dp      <= '0;
`endif
        end else begin
            r_sync1 <= w_bus_in;
            r_s_bus <= r_sync1;
            r_p_bus <= r_s_bus;
            r_cnt   <= w_cnt_nxt;

            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (w_capbit[i]) begin
                    if (w_legal) r_digits[4*i +: 4] <= w_nibble;
                    r_valid[i] <= w_legal;
`ifdef SEG7_SCAN_DP_EN
                    r_dp[i]    <= ~w_s_dp;
`endif
                end
            end

            // A capture landing on the clear cycle seeds the next frame's mask.
            if (&r_seen) begin
                r_frame <= 1'b1;
                r_seen  <= w_capbit;
            end else begin
                r_frame <= 1'b0;
                r_seen  <= r_seen | w_capbit;
            end

            if (err_clr) begin
                r_pat_err <= 1'b0;
                r_sel_err <= 1'b0;
            end
            if ((|w_capbit) && !w_legal)          r_pat_err <= 1'b1;
            if (w_cap && (w_kind == SEL_MULTI))   r_sel_err <= 1'b1;
        end
    end

    assign digits     = r_digits;
    assign dig_valid  = r_valid;
    assign frame_done = r_frame;
    assign pat_err    = r_pat_err;
    assign sel_err    = r_sel_err;

endmodule
